// File: rtl/dkong_hiscore_ctl.sv
// High-score persistence controller: restores a host-supplied score table into
// game RAM once the game has initialised it, and dumps game RAM back on request.
module dkong_hiscore_ctl #(
  parameter logic [15:0] HS_START     = 16'h6100,
  parameter int          HS_LEN       = 40,
  parameter logic [7:0]  START_MARK   = 8'h00,
  parameter logic [7:0]  END_MARK     = 8'h00,
  parameter logic [23:0] CHECK_PERIOD = 24'd2457600
) (
  input  logic        I_CLK_24576M,
  input  logic        I_RESET,
  output logic        O_PAUSE_REQ,
  input  logic        I_PAUSED,
  output logic [15:0] O_HS_ADDR,
  output logic [7:0]  O_HS_DIN,
  input  logic [7:0]  I_HS_DOUT,
  output logic        O_HS_WRITE,
  output logic        O_HS_ACCESS,
  input  logic [5:0]  I_NV_ADDR,
  input  logic [7:0]  I_NV_WDATA,
  input  logic        I_NV_WE,
  output logic [7:0]  O_NV_RDATA,
  input  logic        I_NV_LOADED,
  input  logic        I_SAVE,
  output logic        O_BUSY,
  output logic        O_SAVE_DONE,
  output logic        O_RESTORED
);

  typedef enum logic [2:0] {IDLE, PREQ, CHK_S, CHK_E, REST, DUMP, REL} state_t;

  localparam logic [15:0] END_ADDR = HS_START + 16'(HS_LEN - 1);
  localparam logic [5:0]  LAST_IDX = 6'(HS_LEN - 1);

  logic [7:0]  nv_buf [0:63];

  state_t      state, state_nx;
  logic [5:0]  idx, idx_nx;
  logic [1:0]  ph, ph_nx;
  logic        op_dump, op_nx;
  logic        save_pend, pend_clr;
  logic [23:0] timer;
  logic        timer_ld, dump_we, rest_set, to_rel;
  logic [15:0] addr_nx;
  logic [7:0]  din_nx;
  logic        wr_nx, acc_nx, preq_nx, done_nx;
  logic [5:0]  idx_inc;
  logic        last;

  assign idx_inc = idx + 6'd1;
  assign last    = (idx == LAST_IDX);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    ph_nx    = ph;
    op_nx    = op_dump;
    addr_nx  = O_HS_ADDR;
    din_nx   = O_HS_DIN;
    wr_nx    = O_HS_WRITE;
    acc_nx   = O_HS_ACCESS;
    preq_nx  = O_PAUSE_REQ;
    done_nx  = 1'b0;
    pend_clr = 1'b0;
    timer_ld = 1'b0;
    dump_we  = 1'b0;
    rest_set = 1'b0;
    to_rel   = 1'b0;
    case (state)
      IDLE: begin
        // A save before the restore would overwrite host data, so it is dropped.
        if (save_pend) pend_clr = 1'b1;
        if (save_pend && (O_RESTORED || !I_NV_LOADED)) begin
          state_nx = PREQ;
          op_nx    = 1'b1;
          preq_nx  = 1'b1;
        end else if (I_NV_LOADED && !O_RESTORED && timer == 24'd0) begin
          state_nx = PREQ;
          op_nx    = 1'b0;
          preq_nx  = 1'b1;
        end
      end
      PREQ: begin
        if (I_PAUSED) begin
          acc_nx   = 1'b1;
          wr_nx    = 1'b0;
          addr_nx  = HS_START;
          idx_nx   = 6'd0;
          ph_nx    = 2'd0;
          state_nx = op_dump ? DUMP : CHK_S;
        end
      end
      CHK_S, CHK_E: begin
        if (!I_PAUSED) begin
          to_rel = 1'b1;
        end else if (ph == 2'd2) begin
          if (state == CHK_S && I_HS_DOUT == START_MARK) begin
            state_nx = CHK_E;
            addr_nx  = END_ADDR;
            ph_nx    = 2'd0;
          end else if (state == CHK_E && I_HS_DOUT == END_MARK) begin
            state_nx = REST;
            addr_nx  = HS_START;
            din_nx   = nv_buf[6'd0];
            idx_nx   = 6'd0;
            ph_nx    = 2'd0;
          end else begin
            to_rel = 1'b1;
          end
        end else begin
          ph_nx = ph + 2'd1;
        end
      end
      REST: begin
        if (!I_PAUSED) begin
          to_rel = 1'b1;
        end else if (ph == 2'd0) begin
          wr_nx = 1'b1;
          ph_nx = 2'd1;
        end else if (last) begin
          to_rel   = 1'b1;
          rest_set = 1'b1;
        end else begin
          idx_nx  = idx_inc;
          addr_nx = HS_START + {10'd0, idx_inc};
          din_nx  = nv_buf[idx_inc];
          wr_nx   = 1'b0;
          ph_nx   = 2'd0;
        end
      end
      DUMP: begin
        if (!I_PAUSED) begin
          to_rel = 1'b1;
        end else if (ph == 2'd2) begin
          dump_we = 1'b1;
          if (last) begin
            to_rel  = 1'b1;
            done_nx = 1'b1;
          end else begin
            idx_nx  = idx_inc;
            addr_nx = HS_START + {10'd0, idx_inc};
            ph_nx   = 2'd0;
          end
        end else begin
          ph_nx = ph + 2'd1;
        end
      end
      REL: begin
        state_nx = IDLE;
        timer_ld = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (to_rel) begin
      state_nx = REL;
      acc_nx   = 1'b0;
      wr_nx    = 1'b0;
      preq_nx  = 1'b0;
    end
  end

  always_ff @(posedge I_CLK_24576M) begin
    if (I_RESET) begin
      state       <= IDLE;
      idx         <= 6'd0;
      ph          <= 2'd0;
      op_dump     <= 1'b0;
      save_pend   <= 1'b0;
      timer       <= CHECK_PERIOD;
      O_PAUSE_REQ <= 1'b0;
      O_HS_ADDR   <= 16'h0000;
      O_HS_DIN    <= 8'h00;
      O_HS_WRITE  <= 1'b0;
      O_HS_ACCESS <= 1'b0;
      O_BUSY      <= 1'b0;
      O_SAVE_DONE <= 1'b0;
      O_RESTORED  <= 1'b0;
      O_NV_RDATA  <= 8'h00;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      ph          <= ph_nx;
      op_dump     <= op_nx;
      O_PAUSE_REQ <= preq_nx;
      O_HS_ADDR   <= addr_nx;
      O_HS_DIN    <= din_nx;
      O_HS_WRITE  <= wr_nx;
      O_HS_ACCESS <= acc_nx;
      O_BUSY      <= (state_nx != IDLE);
      O_SAVE_DONE <= done_nx;
      O_NV_RDATA  <= nv_buf[I_NV_ADDR];
      if (!I_NV_LOADED)  O_RESTORED <= 1'b0;
      else if (rest_set) O_RESTORED <= 1'b1;
      if (I_SAVE)        save_pend <= 1'b1;
      else if (pend_clr) save_pend <= 1'b0;
      if (timer_ld)                            timer <= CHECK_PERIOD;
      else if (state == IDLE && timer != 24'd0) timer <= timer - 24'd1;
    end
  end

  // The host port only writes while idle, so it never races the dump writes.
  always_ff @(posedge I_CLK_24576M) begin
    if (dump_we)                nv_buf[idx]       <= I_HS_DOUT;
    else if (I_NV_WE && !O_BUSY) nv_buf[I_NV_ADDR] <= I_NV_WDATA;
  end

endmodule

// File: tb/tb_dkong_hiscore_ctl.sv
// Directed bench for dkong_hiscore_ctl with a small game-RAM model behind the hs port.
module tb_dkong_hiscore_ctl;

  localparam logic [23:0] PERIOD = 24'd40;

  logic        clk = 1'b0;
  logic        I_RESET, paused, I_NV_WE, I_NV_LOADED, I_SAVE;
  logic [5:0]  I_NV_ADDR;
  logic [7:0]  I_NV_WDATA, I_HS_DOUT;
  logic        O_PAUSE_REQ, O_HS_WRITE, O_HS_ACCESS, O_BUSY, O_SAVE_DONE, O_RESTORED;
  logic [15:0] O_HS_ADDR;
  logic [7:0]  O_HS_DIN, O_NV_RDATA;

  logic [7:0]  gram [0:127];
  logic        gram_fill = 1'b0;
  int          gram_sel = 0;
  int          wr_cnt = 0;
  int          viol = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  dkong_hiscore_ctl #(.CHECK_PERIOD(PERIOD)) dut (
    .I_CLK_24576M(clk), .I_RESET(I_RESET), .O_PAUSE_REQ(O_PAUSE_REQ), .I_PAUSED(paused),
    .O_HS_ADDR(O_HS_ADDR), .O_HS_DIN(O_HS_DIN), .I_HS_DOUT(I_HS_DOUT),
    .O_HS_WRITE(O_HS_WRITE), .O_HS_ACCESS(O_HS_ACCESS),
    .I_NV_ADDR(I_NV_ADDR), .I_NV_WDATA(I_NV_WDATA), .I_NV_WE(I_NV_WE),
    .O_NV_RDATA(O_NV_RDATA), .I_NV_LOADED(I_NV_LOADED), .I_SAVE(I_SAVE),
    .O_BUSY(O_BUSY), .O_SAVE_DONE(O_SAVE_DONE), .O_RESTORED(O_RESTORED)
  );

  function automatic logic [7:0] hb(input int i);
    if (i == 0 || i == 39) return 8'h00;
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [7:0] gpat(input int sel, input int k);
    if (sel == 0) return (k == 0) ? 8'h5A : ((k == 39) ? 8'h00 : 8'h11);
    if (sel == 1) return (k == 0 || k == 39) ? 8'h00 : 8'h11;
    if (k >= 40) return 8'h11;
    return (k == 0 || k == 39) ? 8'h00 : 8'(k * 5 + 33);
  endfunction

  // Game RAM window 0x6100..0x617F; anything else reads as open bus.
  assign I_HS_DOUT = (O_HS_ADDR[15:7] == 9'h0C2) ? gram[O_HS_ADDR[6:0]] : 8'hFF;

  always @(posedge clk) begin
    if (gram_fill) begin
      for (int k = 0; k < 128; k++) gram[k] <= gpat(gram_sel, k);
    end else if (O_HS_WRITE && O_HS_ACCESS && O_HS_ADDR[15:7] == 9'h0C2) begin
      gram[O_HS_ADDR[6:0]] <= O_HS_DIN;
    end
    if (O_HS_WRITE) wr_cnt <= wr_cnt + 1;
    if (O_HS_WRITE && !O_HS_ACCESS) viol <= viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_fill(input int sel);
    gram_sel  = sel;
    gram_fill = 1'b1;
    @(negedge clk);
    gram_fill = 1'b0;
  endtask

  task automatic host_wr(input int a, input int d);
    I_NV_ADDR  = 6'(a);
    I_NV_WDATA = 8'(d);
    I_NV_WE    = 1'b1;
    @(negedge clk);
    I_NV_WE    = 1'b0;
  endtask

  task automatic host_rd(input int a, output logic [7:0] v);
    I_NV_ADDR = 6'(a);
    @(posedge clk);
    #1 v = O_NV_RDATA;
    @(negedge clk);
  endtask

  task automatic pulse_save();
    I_SAVE = 1'b1;
    @(negedge clk);
    I_SAVE = 1'b0;
  endtask

  task automatic wait_preq(input int budget, output int n);
    n = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (O_PAUSE_REQ) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic run_op(input int kill_at, input int budget, output int busy_cyc,
                        output int rest_cyc, output int done_cyc, output int done_n,
                        output int rel_n);
    busy_cyc = -1; rest_cyc = -1; done_cyc = -1; done_n = 0; rel_n = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (O_RESTORED && rest_cyc < 0) rest_cyc = cyc;
      if (O_SAVE_DONE) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (O_BUSY && !O_PAUSE_REQ) rel_n++;
      if (!O_BUSY) begin
        busy_cyc = cyc;
        break;
      end
      if (cyc == kill_at) paused = 1'b0;
    end
  endtask

  initial begin
    int n, w0, errs, bc, rc, dc, dn, rl, gap, dseen;
    logic [7:0] v;
    I_RESET = 1'b1; paused = 1'b0; I_NV_WE = 1'b0; I_NV_LOADED = 1'b0; I_SAVE = 1'b0;
    I_NV_ADDR = 6'd0; I_NV_WDATA = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ctl", 32'({O_PAUSE_REQ, O_HS_WRITE, O_HS_ACCESS, O_BUSY, O_SAVE_DONE, O_RESTORED}), 32'h0);
    check("rst_addr", 32'(O_HS_ADDR), 32'h0);
    check("rst_din", 32'(O_HS_DIN), 32'h0);
    check("rst_rdata", 32'(O_NV_RDATA), 32'h0);
    I_RESET = 1'b0;
    do_fill(0);
    for (int i = 0; i < 64; i++) host_wr(i, int'(hb(i)));
    host_rd(7, v);  check("nv_rd7", 32'(v), 32'(hb(7)));
    host_rd(38, v); check("nv_rd38", 32'(v), 32'(hb(38)));

    // Start marker wrong: PREQ waits for the pause, then the check gives up.
    I_NV_LOADED = 1'b1;
    wait_preq(10, n);
    check("chk_start", 32'(n), 32'd1);
    repeat (3) @(negedge clk);
    check("preq_hold", 32'({O_PAUSE_REQ, O_HS_ACCESS}), 32'h2);
    w0 = wr_cnt;
    paused = 1'b1;
    run_op(-1, 50, bc, rc, dc, dn, rl);
    check("badmark_busy", 32'(bc), 32'd5);
    check("badmark_wr", 32'(wr_cnt - w0), 32'd0);
    check("badmark_rest", 32'(O_RESTORED), 32'd0);
    check("badmark_rel", 32'(rl), 32'd1);

    // Rejected save while waiting for the retry; markers fixed meanwhile.
    gap = -1; dseen = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (O_SAVE_DONE) dseen++;
      if (O_PAUSE_REQ) begin
        gap = c;
        break;
      end
      I_SAVE = (c == 1);
      if (c == 5) begin
        gram_sel  = 1;
        gram_fill = 1'b1;
      end else begin
        gram_fill = 1'b0;
      end
    end
    I_SAVE = 1'b0; gram_fill = 1'b0;
    check("retry_gap", 32'(gap), 32'(PERIOD) + 32'd1);
    check("rej_done", 32'(dseen), 32'd0);

    w0 = wr_cnt;
    run_op(-1, 200, bc, rc, dc, dn, rl);
    check("rest_busy", 32'(bc), 32'd88);
    check("rest_flag_cyc", 32'(rc), 32'd87);
    check("rest_wr", 32'(wr_cnt - w0), 32'd40);
    check("rest_rel", 32'(rl), 32'd1);
    errs = 0;
    for (int k = 0; k < 40; k++) if (gram[k] !== hb(k)) errs++;
    check("rest_data", 32'(errs), 32'd0);
    check("rest_beyond", 32'(gram[40]), 32'h11);
    host_rd(12, v); check("buf_kept", 32'(v), 32'(hb(12)));

    // Dump after restore.
    do_fill(2);
    pulse_save();
    wait_preq(10, n);
    check("save_preq", 32'(n > 0), 32'd1);
    run_op(-1, 300, bc, rc, dc, dn, rl);
    check("dump_busy", 32'(bc), 32'd122);
    check("dump_done_cyc", 32'(dc), 32'd121);
    check("dump_done_n", 32'(dn), 32'd1);
    check("dump_rel", 32'(rl), 32'd1);
    errs = 0;
    for (int k = 0; k < 40; k++) begin
      host_rd(k, v);
      if (v !== gpat(2, k)) errs++;
    end
    check("dump_data", 32'(errs), 32'd0);
    host_rd(20, v); check("dump_rd20", 32'(v), 32'h85);
    host_rd(45, v); check("dump_rd45", 32'(v), 32'(hb(45)));

    // Loaded drop clears the flag; restore aborted at byte 10, then retried.
    I_NV_LOADED = 1'b0;
    @(negedge clk);
    check("restored_clr", 32'(O_RESTORED), 32'd0);
    do_fill(1);
    I_NV_LOADED = 1'b1;
    wait_preq(200, n);
    check("abort_preq", 32'(n > 0), 32'd1);
    w0 = wr_cnt;
    run_op(27, 200, bc, rc, dc, dn, rl);
    check("abort_busy", 32'(bc), 32'd29);
    check("abort_wr", 32'(wr_cnt - w0), 32'd10);
    check("abort_rest", 32'(O_RESTORED), 32'd0);
    paused = 1'b1;
    wait_preq(200, n);
    check("abort_retry_gap", 32'(n), 32'(PERIOD) + 32'd1);
    run_op(-1, 200, bc, rc, dc, dn, rl);
    check("retry_busy", 32'(bc), 32'd88);
    check("retry_rest", 32'(O_RESTORED), 32'd1);
    errs = 0;
    for (int k = 0; k < 40; k++) if (gram[k] !== gpat(2, k)) errs++;
    check("retry_data", 32'(errs), 32'd0);

    // Reset in the middle of a dump; a host write while busy must be dropped.
    pulse_save();
    wait_preq(10, n);
    repeat (30) @(negedge clk);
    host_wr(50, 8'hEE);
    I_RESET = 1'b1;
    @(negedge clk);
    check("mid_rst_ctl", 32'({O_PAUSE_REQ, O_HS_WRITE, O_HS_ACCESS, O_BUSY, O_SAVE_DONE, O_RESTORED}), 32'h0);
    check("mid_rst_addr", 32'(O_HS_ADDR), 32'h0);
    check("mid_rst_din", 32'(O_HS_DIN), 32'h0);
    check("mid_rst_rdata", 32'(O_NV_RDATA), 32'h0);
    I_RESET = 1'b0;
    host_wr(3, 8'hC3);
    host_rd(3, v);  check("post_rst_wr", 32'(v), 32'hC3);
    host_rd(50, v); check("busy_wr_drop", 32'(v), 32'(hb(50)));
    check("wr_wo_access", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
